// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU. A single operation
// is in flight at a time; its result is held for the granted port until consumed.
module alu_arbiter #(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             a_ready,
  output logic             b_ready,
  input  logic [3:0]       a_ctrl,
  input  logic [3:0]       b_ctrl,
  input  logic [31:0]      a_op1,
  input  logic [31:0]      a_op2,
  input  logic [31:0]      b_op1,
  input  logic [31:0]      b_op2,
  output logic             a_rsp_valid,
  output logic             b_rsp_valid,
  input  logic             a_rsp_ready,
  input  logic             b_rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [3:0]       alu_ctrl,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] a_done_cnt,
  output logic [CNT_W-1:0] b_done_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nx;
  logic        last_b;
  logic        lat_b;
  logic [3:0]  lat_ctrl;
  logic [31:0] lat_op1, lat_op2;
  logic        gnt_a, gnt_b, req_hs, rsp_hs;

  // A wins contention under fixed priority, or when B was granted last.
  always_comb begin
    gnt_a = a_valid && (!b_valid || (RR_EN == 0) || last_b);
    gnt_b = b_valid && !gnt_a;
  end

  always_comb begin
    state_nx    = state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    alu_ctrl    = 4'b0010;
    alu_op1     = '0;
    alu_op2     = '0;
    req_hs      = 1'b0;
    rsp_hs      = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held
        a_ready = rst_n && gnt_a;
        b_ready = rst_n && gnt_b;
        req_hs  = gnt_a || gnt_b;
        if (req_hs) state_nx = EXEC;
      end
      EXEC: begin
        alu_ctrl = lat_ctrl;
        alu_op1  = lat_op1;
        alu_op2  = lat_op2;
        state_nx = RESP;
      end
      RESP: begin
        a_rsp_valid = !lat_b;
        b_rsp_valid = lat_b;
        rsp_hs      = lat_b ? b_rsp_ready : a_rsp_ready;
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      lat_b      <= 1'b0;
      lat_ctrl   <= '0;
      lat_op1    <= '0;
      lat_op2    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      a_done_cnt <= '0;
      b_done_cnt <= '0;
    end else begin
      state <= state_nx;
      if (req_hs) begin
        last_b   <= gnt_b;
        lat_b    <= gnt_b;
        lat_ctrl <= gnt_b ? b_ctrl : a_ctrl;
        lat_op1  <= gnt_b ? b_op1 : a_op1;
        lat_op2  <= gnt_b ? b_op2 : a_op2;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
      if (rsp_hs) begin
        if (lat_b) begin
          if (b_done_cnt != '1) b_done_cnt <= b_done_cnt + CNT_W'(1);
        end else begin
          if (a_done_cnt != '1) a_done_cnt <= a_done_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin/16-bit instance and a fixed-priority/2-bit instance
// share stimulus, each with its own behavioural ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_rsp_ready, b_rsp_ready;
  logic [3:0]  a_ctrl, b_ctrl;
  logic [31:0] a_op1, a_op2, b_op1, b_op2;

  logic        m_a_ready, m_b_ready, m_a_rsp_valid, m_b_rsp_valid, m_rsp_zero, m_busy, m_alu_zero;
  logic [31:0] m_rsp_result, m_alu_op1, m_alu_op2, m_alu_result;
  logic [3:0]  m_alu_ctrl;
  logic [15:0] m_a_cnt, m_b_cnt;

  logic        f_a_ready, f_b_ready, f_a_rsp_valid, f_b_rsp_valid, f_rsp_zero, f_busy, f_alu_zero;
  logic [31:0] f_rsp_result, f_alu_op1, f_alu_op2, f_alu_result;
  logic [3:0]  f_alu_ctrl;
  logic [1:0]  f_a_cnt, f_b_cnt;

  int checks = 0;
  int errors = 0;
  int m_ea, m_eb, f_ea, f_eb;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] x, logic [31:0] y);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b1000: return {31'b0, x != y};
      4'b1001: return {31'b0, x == y};
      default: return 32'd0;
    endcase
  endfunction

  assign m_alu_result = alu_f(m_alu_ctrl, m_alu_op1, m_alu_op2);
  assign m_alu_zero   = (m_alu_result == 32'd0);
  assign f_alu_result = alu_f(f_alu_ctrl, f_alu_op1, f_alu_op2);
  assign f_alu_zero   = (f_alu_result == 32'd0);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(m_a_ready), .b_ready(m_b_ready),
    .a_ctrl(a_ctrl), .b_ctrl(b_ctrl), .a_op1(a_op1), .a_op2(a_op2), .b_op1(b_op1), .b_op2(b_op2),
    .a_rsp_valid(m_a_rsp_valid), .b_rsp_valid(m_b_rsp_valid),
    .a_rsp_ready(a_rsp_ready), .b_rsp_ready(b_rsp_ready),
    .rsp_result(m_rsp_result), .rsp_zero(m_rsp_zero),
    .alu_ctrl(m_alu_ctrl), .alu_op1(m_alu_op1), .alu_op2(m_alu_op2),
    .alu_result(m_alu_result), .alu_zero(m_alu_zero),
    .a_done_cnt(m_a_cnt), .b_done_cnt(m_b_cnt), .busy(m_busy)
  );

  alu_arbiter #(.RR_EN(0), .CNT_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(f_a_ready), .b_ready(f_b_ready),
    .a_ctrl(a_ctrl), .b_ctrl(b_ctrl), .a_op1(a_op1), .a_op2(a_op2), .b_op1(b_op1), .b_op2(b_op2),
    .a_rsp_valid(f_a_rsp_valid), .b_rsp_valid(f_b_rsp_valid),
    .a_rsp_ready(a_rsp_ready), .b_rsp_ready(b_rsp_ready),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero),
    .alu_ctrl(f_alu_ctrl), .alu_op1(f_alu_op1), .alu_op2(f_alu_op2),
    .alu_result(f_alu_result), .alu_zero(f_alu_zero),
    .a_done_cnt(f_a_cnt), .b_done_cnt(f_b_cnt), .busy(f_busy)
  );

  typedef struct {
    logic        is_b;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    a_ctrl = 4'b0010; b_ctrl = 4'b0010;
    a_op1 = 32'd1; a_op2 = 32'd1; b_op1 = 32'd1; b_op2 = 32'd1;
    #1;
    chk("rst a_ready", m_a_ready, 0);
    chk("rst b_ready", m_b_ready, 0);
    chk("rst a_rsp_valid", m_a_rsp_valid, 0);
    chk("rst b_rsp_valid", m_b_rsp_valid, 0);
    chk("rst busy", m_busy, 0);
    chk("rst alu_ctrl", m_alu_ctrl, 4'b0010);
    chk("rst alu_op1", m_alu_op1, 0);
    chk("rst alu_op2", m_alu_op2, 0);
    chk("rst rsp_result", m_rsp_result, 0);
    chk("rst rsp_zero", m_rsp_zero, 0);
    chk("rst a_cnt", m_a_cnt, 0);
    chk("rst b_cnt", m_b_cnt, 0);
    chk("rst fp a_ready", f_a_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ea = 0; m_eb = 0; f_ea = 0; f_eb = 0;
  endtask

  // Full single-port transaction: IDLE grant, EXEC drive, RESP result, counter update.
  task automatic run_op(logic is_b, logic [3:0] ctrl, logic [31:0] op1, logic [31:0] op2,
                        logic [31:0] res, logic zero);
    @(negedge clk);
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    if (is_b) begin
      a_valid = 1'b0; b_valid = 1'b1; b_ctrl = ctrl; b_op1 = op1; b_op2 = op2;
    end else begin
      b_valid = 1'b0; a_valid = 1'b1; a_ctrl = ctrl; a_op1 = op1; a_op2 = op2;
    end
    #1;
    chk("op a_ready", m_a_ready, !is_b);
    chk("op b_ready", m_b_ready, is_b);
    chk("op fp ready", is_b ? f_b_ready : f_a_ready, 1);
    chk("op idle busy", m_busy, 0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    a_op1 = ~op1; b_op1 = ~op1; a_ctrl = 4'b0001; b_ctrl = 4'b0001;
    #1;
    chk("exec busy", m_busy, 1);
    chk("exec alu_ctrl", m_alu_ctrl, ctrl);
    chk("exec alu_op1", m_alu_op1, op1);
    chk("exec alu_op2", m_alu_op2, op2);
    chk("exec rsp_valid", m_a_rsp_valid | m_b_rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("resp a_rsp_valid", m_a_rsp_valid, !is_b);
    chk("resp b_rsp_valid", m_b_rsp_valid, is_b);
    chk("resp result", m_rsp_result, res);
    chk("resp zero", m_rsp_zero, zero);
    chk("resp fp result", f_rsp_result, res);
    if (is_b) begin
      m_eb++; if (f_eb < 3) f_eb++;
    end else begin
      m_ea++; if (f_ea < 3) f_ea++;
    end
    @(negedge clk);
    #1;
    chk("done busy", m_busy, 0);
    chk("done a_cnt", m_a_cnt, m_ea);
    chk("done b_cnt", m_b_cnt, m_eb);
    chk("done fp a_cnt", f_a_cnt, f_ea);
    chk("done fp b_cnt", f_b_cnt, f_eb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'b0010, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1] = '{1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0};
    vecs[3] = '{1'b1, 4'b0110, 32'd9,        32'd9,        32'd0,        1'b1};
    vecs[4] = '{1'b0, 4'b1000, 32'd3,        32'd3,        32'd0,        1'b1};
    vecs[5] = '{1'b0, 4'b1000, 32'd3,        32'd4,        32'd1,        1'b0};
    vecs[6] = '{1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[7] = '{1'b0, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].is_b, vecs[i].ctrl, vecs[i].op1, vecs[i].op2, vecs[i].res, vecs[i].zero);

    // Contention: RR instance alternates A,B,A,B; fixed-priority instance always A
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    a_ctrl = 4'b0010; a_op1 = 32'd1; a_op2 = 32'd1;
    b_ctrl = 4'b0010; b_op1 = 32'd2; b_op2 = 32'd2;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr a_ready", m_a_ready, (g % 2) == 0);
      chk("rr b_ready", m_b_ready, (g % 2) == 1);
      chk("fp a_ready", f_a_ready, 1);
      chk("fp b_ready", f_b_ready, 0);
      @(negedge clk);
      #1;
      chk("rr exec ready", m_a_ready | m_b_ready, 0);
      @(negedge clk);
      #1;
      chk("rr resp result", m_rsp_result, ((g % 2) == 0) ? 32'd2 : 32'd4);
      chk("fp resp result", f_rsp_result, 2);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rr a_cnt", m_a_cnt, 2);
    chk("rr b_cnt", m_b_cnt, 2);
    chk("fp a_cnt sat", f_a_cnt, 3);
    chk("fp b_cnt", f_b_cnt, 0);

    // Back-pressure on B with A waiting; B operands change after handshake
    do_reset();
    @(negedge clk);
    b_valid = 1'b1; b_ctrl = 4'b0110; b_op1 = 32'd9; b_op2 = 32'd9;
    b_rsp_ready = 1'b0; a_rsp_ready = 1'b1;
    #1;
    chk("bp b_ready", m_b_ready, 1);
    @(negedge clk);
    b_valid = 1'b0; b_op1 = 32'd100;
    a_valid = 1'b1; a_ctrl = 4'b0010; a_op1 = 32'd1; a_op2 = 32'd2;
    #1;
    chk("bp exec a_ready", m_a_ready, 0);
    chk("bp exec alu_op1", m_alu_op1, 9);
    b_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp b_rsp_valid", m_b_rsp_valid, 1);
      chk("bp a_rsp_valid", m_a_rsp_valid, 0);
      chk("bp result", m_rsp_result, 0);
      chk("bp zero", m_rsp_zero, 1);
      chk("bp busy", m_busy, 1);
      chk("bp a_ready", m_a_ready, 0);
      chk("bp b_ready", m_b_ready, 0);
      b_valid = 1'b0;
    end
    @(negedge clk);
    b_rsp_ready = 1'b1;
    #1;
    chk("bp still valid", m_b_rsp_valid, 1);
    @(negedge clk);
    b_rsp_ready = 1'b0;
    #1;
    chk("bp b_cnt", m_b_cnt, 1);
    chk("bp a_cnt", m_a_cnt, 0);
    chk("bp idle busy", m_busy, 0);
    chk("bp a_ready after", m_a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("bp a exec op1", m_alu_op1, 1);
    @(negedge clk);
    #1;
    chk("bp a result", m_rsp_result, 3);
    chk("bp a_rsp_valid", m_a_rsp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp a_cnt after", m_a_cnt, 1);

    // Reset while in RESP discards the operation
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_ctrl = 4'b0010; a_op1 = 32'd5; a_op2 = 32'd7; a_rsp_ready = 1'b0;
    #1;
    chk("rr2 a_ready", m_a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rr2 a_rsp_valid", m_a_rsp_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rr2 rst a_rsp_valid", m_a_rsp_valid, 0);
    chk("rr2 rst busy", m_busy, 0);
    chk("rr2 rst a_cnt", m_a_cnt, 0);
    chk("rr2 rst result", m_rsp_result, 0);
    a_valid = 1'b1; b_valid = 1'b1; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    a_op1 = 32'd20; a_op2 = 32'd22; b_ctrl = 4'b0010; b_op1 = 32'd3; b_op2 = 32'd3;
    #1;
    chk("rr2 rst a_ready", m_a_ready, 0);
    chk("rr2 rst b_ready", m_b_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr2 post a_ready", m_a_ready, 1);
    chk("rr2 post b_ready", m_b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rr2 first grant busy", m_busy, 1);
    chk("rr2 first grant op1", m_alu_op1, 20);
    @(negedge clk);
    #1;
    chk("rr2 result", m_rsp_result, 42);
    @(negedge clk);
    #1;
    chk("rr2 a_cnt", m_a_cnt, 1);

    // Saturation on the 2-bit instance: 1, 2, 3, 3
    do_reset();
    for (int i = 0; i < 4; i++)
      run_op(1'b0, 4'b0010, i, 32'd10, i + 10, 1'b0);
    chk("sat fp a_cnt", f_a_cnt, 3);
    chk("sat main a_cnt", m_a_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
